// File: rtl/load_use_hazard_ctrl_pkg.sv
// hazard_pkg: shared register-address, stall-counter and FSM state definitions for hazard control
package hazard_pkg;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
  localparam int STALL_CNT_W = 4;
  typedef enum logic {IDLE, STALL} state_t;
endpackage

// File: rtl/load_use_hazard_ctrl_detect.sv
// load_use_detect: combinational load-use compare (mem_read/ex_rt vs if_rs/if_rt/uses_rt -> hazard)
module load_use_detect
  import hazard_pkg::*;
(
  input  logic                  mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] if_rs,
  input  logic [REG_ADDR_W-1:0] if_rt,
  input  logic                  uses_rt,
  output logic                  hazard
);
  assign hazard = mem_read && ex_rt != ZERO_REG && (ex_rt == if_rs || (uses_rt && ex_rt == if_rt));
endmodule

// File: rtl/load_use_hazard_ctrl.sv
// load_use_hazard_ctrl: load-use stall FSM (hazard fields in; PCWrite/IF_ID_Write/ID_Flush/IF_Flush, saturating stall_count out)
module load_use_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ID_EX_MemRead_i,
  input  logic [REG_ADDR_W-1:0] ID_EX_RegisterRt_i,
  input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRs_i,
  input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRt_i,
  input  logic                  IF_ID_UsesRt_i,
  input  logic                  Branch_taken_i,
  input  logic                  cnt_clear_i,
  output logic                  PCWrite_o,
  output logic                  IF_ID_Write_o,
  output logic                  ID_Flush_lwstall_o,
  output logic                  IF_Flush_o,
  output logic [CNT_W-1:0]      stall_count_o
);
  localparam logic [STALL_CNT_W-1:0] REM_INIT = STALL_CNT_W'(STALL_CYCLES - 1);
  if (STALL_CYCLES < 1 || STALL_CYCLES > 15) begin : g_bad_stall_cycles
    $error("STALL_CYCLES must be in 1..15");
  end
  state_t state;
  logic [STALL_CNT_W-1:0] rem;
  logic hazard, stall;
  load_use_detect u_detect (
    .mem_read(ID_EX_MemRead_i),
    .ex_rt(ID_EX_RegisterRt_i),
    .if_rs(IF_ID_RegisterRs_i),
    .if_rt(IF_ID_RegisterRt_i),
    .uses_rt(IF_ID_UsesRt_i),
    .hazard(hazard)
  );
  assign stall = state == STALL || hazard;
  always_comb begin
    PCWrite_o = !reset && !stall;
    IF_ID_Write_o = !reset && !stall;
    ID_Flush_lwstall_o = !reset && stall;
    IF_Flush_o = !reset && !stall && Branch_taken_i;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rem <= '0;
    end else if (state == IDLE) begin
      if (hazard && STALL_CYCLES > 1) begin
        state <= STALL;
        rem <= REM_INIT;
      end
    end else begin
      rem <= rem - 1'b1;
      state <= rem == STALL_CNT_W'(1) ? IDLE : STALL;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_count_o <= '0;
    else if (cnt_clear_i) stall_count_o <= '0;
    else if (stall && stall_count_o != '1) stall_count_o <= stall_count_o + 1'b1;
  end
endmodule

// File: tb/tb_load_use_hazard_ctrl.sv
// tb_load_use_hazard_ctrl: directed and random checks of three load_use_hazard_ctrl configurations against a cycle model
module tb_load_use_hazard_ctrl;
  logic clk = 0;
  logic reset = 1;
  logic mem_read = 0, uses_rt = 0, br = 0, clr = 0;
  logic [4:0] ex_rt = 0, if_rs = 0, if_rt = 0;
  logic [2:0] pcw, ifw, fl, ifl;
  logic [31:0] c1, c3;
  logic [3:0] c4;
  int n_cmp = 0, n_err = 0;
  int sc[3] = '{1, 3, 4};
  longint cmax[3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 15};
  int busy[3];
  longint cnt[3];
  always #5 clk = ~clk;
  load_use_hazard_ctrl #(.STALL_CYCLES(1), .CNT_W(32)) u1 (
    .clk(clk), .reset(reset), .ID_EX_MemRead_i(mem_read), .ID_EX_RegisterRt_i(ex_rt),
    .IF_ID_RegisterRs_i(if_rs), .IF_ID_RegisterRt_i(if_rt), .IF_ID_UsesRt_i(uses_rt),
    .Branch_taken_i(br), .cnt_clear_i(clr), .PCWrite_o(pcw[0]), .IF_ID_Write_o(ifw[0]),
    .ID_Flush_lwstall_o(fl[0]), .IF_Flush_o(ifl[0]), .stall_count_o(c1));
  load_use_hazard_ctrl #(.STALL_CYCLES(3), .CNT_W(32)) u3 (
    .clk(clk), .reset(reset), .ID_EX_MemRead_i(mem_read), .ID_EX_RegisterRt_i(ex_rt),
    .IF_ID_RegisterRs_i(if_rs), .IF_ID_RegisterRt_i(if_rt), .IF_ID_UsesRt_i(uses_rt),
    .Branch_taken_i(br), .cnt_clear_i(clr), .PCWrite_o(pcw[1]), .IF_ID_Write_o(ifw[1]),
    .ID_Flush_lwstall_o(fl[1]), .IF_Flush_o(ifl[1]), .stall_count_o(c3));
  load_use_hazard_ctrl #(.STALL_CYCLES(4), .CNT_W(4)) u4 (
    .clk(clk), .reset(reset), .ID_EX_MemRead_i(mem_read), .ID_EX_RegisterRt_i(ex_rt),
    .IF_ID_RegisterRs_i(if_rs), .IF_ID_RegisterRt_i(if_rt), .IF_ID_UsesRt_i(uses_rt),
    .Branch_taken_i(br), .cnt_clear_i(clr), .PCWrite_o(pcw[2]), .IF_ID_Write_o(ifw[2]),
    .ID_Flush_lwstall_o(fl[2]), .IF_Flush_o(ifl[2]), .stall_count_o(c4));
  task automatic chk(input string name, input longint got, input longint want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask
  function automatic bit haz();
    return mem_read && ex_rt != 0 && (ex_rt == if_rs || (uses_rt && ex_rt == if_rt));
  endfunction
  function automatic longint dut_cnt(input int i);
    return i == 0 ? longint'(c1) : i == 1 ? longint'(c3) : longint'(c4);
  endfunction
  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        busy[i] = 0;
        cnt[i] = 0;
      end else begin
        if (clr) cnt[i] = 0;
        else if ((busy[i] > 0 || haz()) && cnt[i] < cmax[i]) cnt[i]++;
        if (busy[i] > 0) busy[i]--;
        else if (haz()) busy[i] = sc[i] - 1;
      end
    end
  end
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      bit st;
      st = !reset && (busy[i] > 0 || haz());
      chk($sformatf("PCWrite[%0d]", i), longint'(pcw[i]), longint'(!reset && !st));
      chk($sformatf("IF_ID_Write[%0d]", i), longint'(ifw[i]), longint'(!reset && !st));
      chk($sformatf("ID_Flush[%0d]", i), longint'(fl[i]), longint'(st));
      chk($sformatf("IF_Flush[%0d]", i), longint'(ifl[i]), longint'(!reset && !st && br));
      chk($sformatf("stall_count[%0d]", i), dut_cnt(i), cnt[i]);
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set(input bit m, input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt, input bit u, input bit b);
    mem_read = m; ex_rt = ert; if_rs = rs; if_rt = rt; uses_rt = u; br = b;
  endtask
  initial begin
    #2;
    chk("lit reset pcw", longint'(pcw), 0);
    chk("lit reset cnt", longint'(c1), 0);
    step(); step();
    reset = 0;
    #1 chk("lit idle pcw", longint'(pcw), 7);
    step(); set(1, 2, 2, 0, 0, 1);
    #1 chk("lit lw pcw u1", longint'(pcw[0]), 0);
    chk("lit lw flush", longint'(fl), 7);
    chk("lit lw branch suppressed", longint'(ifl), 0);
    step(); set(0, 2, 2, 0, 0, 0);
    #1 chk("lit u1 released", longint'(pcw[0]), 1);
    chk("lit u1 count 1", longint'(c1), 1);
    chk("lit u3 still stalled", longint'(pcw[1]), 0);
    step(); br = 1;
    #1 chk("lit u3 stall branch", longint'(ifl[1]), 0);
    chk("lit u1 branch flush", longint'(ifl[0]), 1);
    step(); br = 0;
    #1 chk("lit u3 released", longint'(pcw[1]), 1);
    chk("lit u3 count 3", longint'(c3), 3);
    step(); set(1, 0, 0, 0, 1, 0);
    #1 chk("lit r0 no stall", longint'(pcw[0]), 1);
    step(); set(1, 2, 5, 2, 0, 0);
    #1 chk("lit rt unused", longint'(pcw[0]), 1);
    step(); uses_rt = 1;
    #1 chk("lit rt used", longint'(pcw[0]), 0);
    step(); set(0, 0, 0, 0, 0, 0);
    repeat (5) step();
    set(1, 3, 3, 0, 0, 0);
    step(); mem_read = 0;
    step();
    reset = 1;
    #1 chk("lit u4 reset pcw", longint'(pcw[2]), 0);
    chk("lit u4 reset flush", longint'(fl[2]), 0);
    chk("lit u4 reset cnt", longint'(c4), 0);
    step(); reset = 0;
    #1 chk("lit u4 after reset", longint'(pcw[2]), 1);
    set(1, 2, 2, 0, 0, 0);
    repeat (20) step();
    chk("lit u4 saturated", longint'(c4), 15);
    clr = 1;
    step(); clr = 0;
    #1 chk("lit u4 cleared", longint'(c4), 0);
    for (int k = 0; k < 3000; k++) begin
      step();
      set($urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 1));
      clr = $urandom_range(0, 49) == 0;
      reset = $urandom_range(0, 199) == 0;
    end
    step(); reset = 0;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
